// File: rtl/pipeline_pkg.sv
// Shared pipeline types: MEM/WB register layout, long-latency writeback
// entry, ResultSrc encodings and a register one-hot helper.
package pipeline_pkg;

  localparam int unsigned PL_XLEN = 32;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;
  localparam logic [1:0] RES_IMM  = 2'b11;

  typedef struct packed {
    logic [PL_XLEN-1:0] ALUResult;
    logic [PL_XLEN-1:0] load_data;
    logic [PL_XLEN-1:0] PCPlus4;
    logic [PL_XLEN-1:0] ImmExt;
    logic [1:0]         ResultSrc;
    logic [4:0]         Rd;
    logic               RegWrite;
  } memwb_t;

  typedef struct packed {
    logic [4:0]         rd;
    logic [PL_XLEN-1:0] data;
  } ll_wb_t;

  // One-hot register mask for a 5-bit register index.
  function automatic logic [31:0] reg_onehot(input logic [4:0] r);
    logic [31:0] m;
    m    = '0;
    m[r] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/mux4.sv
// Generic 4:1 multiplexer.
// Ports: d0_i..d3_i data inputs, sel_i 2-bit select, y_o selected data.
module mux4 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] d0_i,
  input  logic [W-1:0] d1_i,
  input  logic [W-1:0] d2_i,
  input  logic [W-1:0] d3_i,
  input  logic [1:0]   sel_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = d0_i;
    unique case (sel_i)
      2'd0:    y_o = d0_i;
      2'd1:    y_o = d1_i;
      2'd2:    y_o = d2_i;
      default: y_o = d3_i;
    endcase
  end

endmodule

// File: rtl/wb_fifo.sv
// Synchronous FIFO of long-latency writeback entries.
// Ports: clk_i, reset_i (sync, active-high); push_i/push_data_i enqueue;
// pop_i dequeue; head_o oldest entry; full_o/empty_o/count_o status;
// valid_o/entries_o raw storage with per-slot occupancy for pending tracking.
module wb_fifo
  import pipeline_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  ll_wb_t                     push_data_i,
  input  logic                       pop_i,
  output ll_wb_t                     head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           valid_o,
  output ll_wb_t [DEPTH-1:0]         entries_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  ll_wb_t [DEPTH-1:0] mem_q;
  logic   [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic   [CNT_W-1:0] count_q;
  logic               do_push, do_pop;

  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign do_push   = push_i & ~full_o;
  assign do_pop    = pop_i & ~empty_o;
  assign head_o    = mem_q[rd_ptr_q];
  assign count_o   = count_q;
  assign entries_o = mem_q;

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Slot i is live when its distance from the read pointer is below count.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      valid_o[i] = ({1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < count_q);
    end
  end

endmodule

// File: rtl/wb_arbiter_stage.sv
// Writeback stage arbitrating one register-file write port between the
// in-order pipeline and NLL long-latency result channels buffered in a FIFO.
// Optional macro WB_BYPASS_EN: lets an LL result write the port directly
// when the FIFO is empty and the port is otherwise idle.
// Ports: clk, reset (sync, active-high); inputs/inputs_valid MEM/WB slot;
// ll_valid/ll_rd/ll_data LL channels, ll_ready acceptance; RegWriteW/RdW/
// ResultW write port; StallW pipeline write refused; pending_mask registers
// targeted by buffered entries; ll_count FIFO occupancy.
module wb_arbiter_stage
  import pipeline_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NLL        = 2,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  memwb_t                 inputs,
  input  logic                   inputs_valid,
  input  logic [NLL-1:0]         ll_valid,
  input  logic [NLL*5-1:0]       ll_rd,
  input  logic [NLL*XLEN-1:0]    ll_data,
  output logic [NLL-1:0]         ll_ready,
  output logic                   RegWriteW,
  output logic [4:0]             RdW,
  output logic [XLEN-1:0]        ResultW,
  output logic                   StallW,
  output logic [31:0]            pending_mask,
  output logic [$clog2(DEPTH):0] ll_count
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned AGE_W = $clog2(STARVE_MAX + 1);

  ll_wb_t               fifo_head, push_entry;
  ll_wb_t [DEPTH-1:0]   fifo_entries;
  logic   [DEPTH-1:0]   fifo_valid;
  logic                 fifo_full, fifo_empty;
  logic   [CNT_W-1:0]   fifo_count;
  logic                 push, pop, bypass;

  logic                 pipe_wr, force_drain;
  logic   [PL_XLEN-1:0] pipe_result;

  logic                 ll_any;
  logic   [NLL-1:0]     ll_sel_oh;
  logic   [4:0]         ll_sel_rd;
  logic   [XLEN-1:0]    ll_sel_data;

  logic   [AGE_W-1:0]   age_q, age_d;

  assign pipe_wr     = inputs_valid & inputs.RegWrite & (inputs.Rd != 5'd0);
  assign force_drain = ~fifo_empty & (age_q == AGE_W'(STARVE_MAX));

  mux4 #(.W(PL_XLEN)) u_result_mux (
    .d0_i  (inputs.ALUResult),
    .d1_i  (inputs.load_data),
    .d2_i  (inputs.PCPlus4),
    .d3_i  (inputs.ImmExt),
    .sel_i (inputs.ResultSrc),
    .y_o   (pipe_result)
  );

  // Fixed priority: scanning downwards lets the lowest valid index win.
  always_comb begin
    ll_any      = 1'b0;
    ll_sel_oh   = '0;
    ll_sel_rd   = '0;
    ll_sel_data = '0;
    for (int i = int'(NLL) - 1; i >= 0; i--) begin
      if (ll_valid[i]) begin
        ll_any       = 1'b1;
        ll_sel_oh    = '0;
        ll_sel_oh[i] = 1'b1;
        ll_sel_rd    = ll_rd[i*5 +: 5];
        ll_sel_data  = ll_data[i*XLEN +: XLEN];
      end
    end
  end

  // Port arbitration: starved FIFO head > pipeline > FIFO drain > bypass.
  always_comb begin
    RegWriteW = 1'b0;
    RdW       = '0;
    ResultW   = '0;
    StallW    = 1'b0;
    ll_ready  = '0;
    pop       = 1'b0;
    push      = 1'b0;
    bypass    = 1'b0;
    if (!reset) begin
      if (force_drain) begin
        RegWriteW = 1'b1;
        RdW       = fifo_head.rd;
        ResultW   = XLEN'(fifo_head.data);
        pop       = 1'b1;
        StallW    = pipe_wr;
      end else if (pipe_wr) begin
        RegWriteW = 1'b1;
        RdW       = inputs.Rd;
        ResultW   = XLEN'(pipe_result);
      end else if (!fifo_empty) begin
        RegWriteW = 1'b1;
        RdW       = fifo_head.rd;
        ResultW   = XLEN'(fifo_head.data);
        pop       = 1'b1;
`ifdef WB_BYPASS_EN
      end else if (ll_any) begin
        RegWriteW = 1'b1;
        RdW       = ll_sel_rd;
        ResultW   = ll_sel_data;
        bypass    = 1'b1;
`endif
      end
      // No acceptance while full, even if the head pops this cycle.
      if (!fifo_full && ll_any) begin
        ll_ready = ll_sel_oh;
        push     = ~bypass & (ll_sel_rd != 5'd0);
      end
    end
  end

  assign push_entry = '{rd: ll_sel_rd, data: PL_XLEN'(ll_sel_data)};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i       (clk),
    .reset_i     (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .valid_o     (fifo_valid),
    .entries_o   (fifo_entries)
  );

  // Head age: clears on pop or when empty, saturates at STARVE_MAX.
  always_comb begin
    age_d = age_q;
    if (fifo_empty || pop)                 age_d = '0;
    else if (age_q != AGE_W'(STARVE_MAX))  age_d = age_q + AGE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end

  always_comb begin
    pending_mask = '0;
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (fifo_valid[i]) pending_mask = pending_mask | reg_onehot(fifo_entries[i].rd);
      end
    end
  end

  assign ll_count = reset ? '0 : fifo_count;

endmodule

// File: tb/tb_wb_arbiter_stage.sv
module tb_wb_arbiter_stage;
  import pipeline_pkg::*;

  localparam int XLEN = 32, NLL = 2, DEPTH = 4, STARVE_MAX = 8;

  logic                   clk = 1'b0;
  logic                   reset;
  memwb_t                 inputs;
  logic                   inputs_valid;
  logic [NLL-1:0]         ll_valid;
  logic [NLL*5-1:0]       ll_rd;
  logic [NLL*XLEN-1:0]    ll_data;
  logic [NLL-1:0]         ll_ready;
  logic                   RegWriteW;
  logic [4:0]             RdW;
  logic [XLEN-1:0]        ResultW;
  logic                   StallW;
  logic [31:0]            pending_mask;
  logic [$clog2(DEPTH):0] ll_count;

  wb_arbiter_stage #(.XLEN(XLEN), .NLL(NLL), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset), .inputs(inputs), .inputs_valid(inputs_valid),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data), .ll_ready(ll_ready),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW), .StallW(StallW),
    .pending_mask(pending_mask), .ll_count(ll_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue plus head waiting time.
  typedef struct { int rd; logic [31:0] data; } ent_t;
  ent_t q[$];
  int   age = 0;

  // Drive one cycle of inputs, compare all outputs against the model,
  // then advance the model to the next cycle.
  task automatic step(input logic rst, input memwb_t in, input logic v,
                      input logic [NLL-1:0] llv, input logic [NLL*5-1:0] llrd,
                      input logic [NLL*XLEN-1:0] lld);
    bit          e_we, e_stall, popped, byp, empty, full, frc, pw;
    int          e_rd, sel, n, srd;
    logic [31:0] e_res, e_mask, pres, sdata;
    logic [NLL-1:0] e_rdy;
    @(negedge clk);
    reset = rst; inputs = in; inputs_valid = v;
    ll_valid = llv; ll_rd = llrd; ll_data = lld;
    #1;
    e_we = 0; e_stall = 0; e_rd = 0; e_res = 0; e_rdy = '0; e_mask = 0;
    popped = 0; byp = 0; sel = -1; srd = 0; sdata = 0;
    n = q.size();
    if (!rst) begin
      empty = (n == 0);
      full  = (n == DEPTH);
      frc   = !empty && (age == STARVE_MAX);
      pw    = v && in.RegWrite && (in.Rd != 0);
      case (in.ResultSrc)
        RES_ALU:  pres = in.ALUResult;
        RES_LOAD: pres = in.load_data;
        RES_PC4:  pres = in.PCPlus4;
        default:  pres = in.ImmExt;
      endcase
      for (int i = 0; i < NLL; i++)
        if (llv[i] && sel < 0) begin
          sel = i; srd = int'(llrd[i*5 +: 5]); sdata = lld[i*XLEN +: XLEN];
        end
      if (frc) begin
        e_we = 1; e_rd = q[0].rd; e_res = q[0].data; popped = 1; e_stall = pw;
      end else if (pw) begin
        e_we = 1; e_rd = int'(in.Rd); e_res = pres;
      end else if (!empty) begin
        e_we = 1; e_rd = q[0].rd; e_res = q[0].data; popped = 1;
      end
`ifdef WB_BYPASS_EN
      else if (sel >= 0) begin
        e_we = 1; e_rd = srd; e_res = sdata; byp = 1;
      end
`endif
      if (!full && sel >= 0) e_rdy[sel] = 1'b1;
      foreach (q[k]) e_mask[q[k].rd] = 1'b1;
    end
    check_eq("RegWriteW", 64'(RegWriteW), 64'(e_we));
    if (e_we) begin
      check_eq("RdW", 64'(RdW), 64'(e_rd));
      check_eq("ResultW", 64'(ResultW), 64'(e_res));
    end
    check_eq("StallW", 64'(StallW), 64'(e_stall));
    check_eq("ll_ready", 64'(ll_ready), 64'(e_rdy));
    check_eq("pending_mask", 64'(pending_mask), 64'(e_mask));
    check_eq("ll_count", 64'(ll_count), rst ? 64'd0 : 64'(n));
    if (rst) begin
      q.delete(); age = 0;
    end else begin
      if (popped) void'(q.pop_front());
      if (n < DEPTH && sel >= 0 && !byp && srd != 0) q.push_back('{rd: srd, data: sdata});
      if (n == 0 || popped) age = 0;
      else if (age < STARVE_MAX) age = age + 1;
    end
  endtask

  function automatic memwb_t mk(input logic [1:0] src, input logic [4:0] rd, input logic we);
    memwb_t m;
    m.ALUResult = $urandom; m.load_data = $urandom; m.PCPlus4 = $urandom; m.ImmExt = $urandom;
    m.ResultSrc = src; m.Rd = rd; m.RegWrite = we;
    return m;
  endfunction

  memwb_t idle, m;
  int stalls, first_stall;

  initial begin
    idle = mk(RES_ALU, 5'd0, 1'b0);
    reset = 1'b1; inputs = idle; inputs_valid = 0; ll_valid = 0; ll_rd = 0; ll_data = 0;
    repeat (2) step(1, idle, 0, 0, 0, 0);

    // Pipeline-only immediate writeback.
    m = mk(RES_IMM, 5'd5, 1'b1); m.ImmExt = 32'h1234_5000;
    step(0, m, 1, 0, 0, 0);
    check_eq("t1_result", 64'(ResultW), 64'h1234_5000);
    check_eq("t1_rd", 64'(RdW), 64'd5);

    // x0 writes dropped; LL result to x0 accepted but not buffered.
    step(0, mk(RES_ALU, 5'd0, 1'b1), 1, 0, 0, 0);
    check_eq("t2_we_x0", 64'(RegWriteW), 64'd0);
    step(0, mk(RES_ALU, 5'd4, 1'b1), 1, 2'b01, 10'd0, 64'h1);
    check_eq("t2_rdy", 64'(ll_ready), 64'd1);
    step(0, idle, 0, 0, 0, 0);
    check_eq("t2_cnt", 64'(ll_count), 64'd0);

    // Two channels at once: ch0 first, ch1 next cycle.
    step(0, idle, 0, 2'b11, {5'd9, 5'd7}, {32'hB, 32'hA});
    step(0, idle, 0, 2'b10, {5'd9, 5'd7}, {32'hB, 32'hA});
`ifndef WB_BYPASS_EN
    check_eq("t3_rd7", 64'(RdW), 64'd7);
    check_eq("t3_pm7", 64'(pending_mask[7]), 64'd1);
`endif
    step(0, idle, 0, 0, 0, 0);
    check_eq("t3_pm7_clr", 64'(pending_mask[7]), 64'd0);
    repeat (3) step(0, idle, 0, 0, 0, 0);

    // Fill under sustained pipeline writes; head starves, one forced drain.
    stalls = 0; first_stall = -1;
    for (int c = 0; c < 13; c++) begin
      step(0, mk(2'($urandom), 5'd1, 1'b1), 1, (c < 4) ? 2'b01 : 2'b00,
           {5'd0, 5'(10 + c)}, {32'h0, 32'(c + 100)});
      if (StallW) begin
        stalls++;
        if (first_stall < 0) first_stall = c;
      end
      if (c == 8) check_eq("t4_full", 64'(ll_count), 64'd4);
    end
    check_eq("t4_stalls", 64'(stalls), 64'd1);
    check_eq("t4_when", 64'(first_stall), 64'd9);

    // Reset with buffered entries.
    step(1, idle, 0, 0, 0, 0);
    step(0, idle, 0, 0, 0, 0);
    check_eq("t5_cnt", 64'(ll_count), 64'd0);
    check_eq("t5_we", 64'(RegWriteW), 64'd0);

    // Single LL result on ch1, idle port.
    step(0, idle, 0, 2'b10, {5'd3, 5'd0}, {32'h55, 32'h0});
`ifdef WB_BYPASS_EN
    check_eq("t6_byp_rd", 64'(RdW), 64'd3);
    check_eq("t6_byp_we", 64'(RegWriteW), 64'd1);
    step(0, idle, 0, 0, 0, 0);
    check_eq("t6_byp_cnt", 64'(ll_count), 64'd0);
`else
    check_eq("t6_we0", 64'(RegWriteW), 64'd0);
    step(0, idle, 0, 0, 0, 0);
    check_eq("t6_rd", 64'(RdW), 64'd3);
    check_eq("t6_res", 64'(ResultW), 64'h55);
`endif

    // Randomized traffic with shifting pipeline/LL pressure.
    for (int ph = 0; ph < 6; ph++) begin
      int pv, lv;
      pv = (ph % 3 == 0) ? 95 : (ph % 3 == 1) ? 50 : 10;
      lv = (ph < 3) ? 70 : 30;
      for (int c = 0; c < 400; c++) begin
        logic [NLL-1:0] v;
        logic [4:0] r;
        for (int i = 0; i < NLL; i++) v[i] = ($urandom_range(99) < lv);
        r = ($urandom_range(9) == 0) ? 5'd0 : 5'($urandom_range(31));
        step(($urandom_range(199) == 0), mk(2'($urandom), r, 1'($urandom_range(9) != 0)),
             ($urandom_range(99) < pv), v,
             {5'($urandom_range(31)), 5'($urandom_range(31))}, {32'($urandom), 32'($urandom)});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
